// File: rtl/ps2_key_decoder.sv
// -----------------------------------------------------------------------------
// ps2_key_decoder
//
// Turns a stream of PS/2 scan-code set 2 bytes into key events and queues them
// in a small FIFO. Each event is {ext, rel, code[7:0]}: ext marks an E0-prefixed
// key, rel marks a break (key released). The Pause key's E1 sequence collapses
// into a single {1,0,E1} event. Live shift/ctrl/alt flags are maintained from
// the left/right modifier makes and breaks.
//
// Parameters
//   FIFO_DEPTH   event FIFO entries, power of two in 2..16
//
// Ports
//   clk          system clock, all logic on the rising edge
//   reset        synchronous active-low reset
//   scan_code    received byte, meaningful only while code_strobe is high
//   code_strobe  one-cycle pulse per received byte
//   evt_valid    FIFO non-empty, evt_data holds the head event
//   evt_ready    consumer takes the head event when high with evt_valid
//   evt_data     head event {ext, rel, code}; reads 0 while the FIFO is empty
//   shift        left or right shift held
//   ctrl         left or right ctrl held
//   alt          left or right alt held
//   overflow     sticky: an event was dropped because the FIFO was full
//   clear_ovf    clears overflow on the next edge (a same-edge drop wins)
// -----------------------------------------------------------------------------
module ps2_key_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       code_strobe,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [9:0] evt_data,
    output logic       shift,
    output logic       ctrl,
    output logic       alt,
    output logic       overflow,
    input  logic       clear_ovf
);

    localparam int            AW         = $clog2(FIFO_DEPTH);
    localparam int            CW         = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        GOT_E0,
        GOT_F0,
        GOT_E0F0,
        PAUSE
    } state_t;

    // Decoder state
    state_t     state_q, state_d;
    logic [2:0] skip_q, skip_d;
    logic       accept;
    logic       emit;
    logic [9:0] emit_data;

    // Modifier tracking
    logic lshift_q, lshift_d, rshift_q, rshift_d;
    logic lctrl_q, lctrl_d, rctrl_q, rctrl_d;
    logic lalt_q, lalt_d, ralt_q, ralt_d;
    logic shift_q, shift_d, ctrl_q, ctrl_d, alt_q, alt_d;

    // Event FIFO
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          full, push, pop, drop;

    // Bytes arriving while reset is asserted are ignored outright.
    assign accept = code_strobe & reset;

    // -------------------------------------------------------------------------
    // Byte decoder: next state and the event produced by a final byte.
    // -------------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        emit      = 1'b0;
        emit_data = '0;

        if (accept) begin
            case (state_q)
                IDLE: begin
                    case (scan_code)
                        8'hE0: state_d = GOT_E0;
                        8'hF0: state_d = GOT_F0;
                        8'hE1: begin
                            state_d = PAUSE;
                            skip_d  = 3'd7;
                        end
                        // Keyboard status / ack bytes, not keys.
                        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: state_d = IDLE;
                        default: begin
                            emit      = 1'b1;
                            emit_data = {2'b00, scan_code};
                        end
                    endcase
                end

                GOT_E0: begin
                    case (scan_code)
                        8'hF0: state_d = GOT_E0F0;
                        8'hE0: state_d = GOT_E0;
                        // E0 12 / E0 59 are fake shifts wrapped around some
                        // extended keys; they carry no key information.
                        8'h12, 8'h59: state_d = IDLE;
                        default: begin
                            emit      = 1'b1;
                            emit_data = {2'b10, scan_code};
                            state_d   = IDLE;
                        end
                    endcase
                end

                GOT_F0: begin
                    case (scan_code)
                        8'hF0: state_d = GOT_F0;
                        // A prefix after F0 abandons the pending release.
                        8'hE0: state_d = GOT_E0;
                        default: begin
                            emit      = 1'b1;
                            emit_data = {2'b01, scan_code};
                            state_d   = IDLE;
                        end
                    endcase
                end

                GOT_E0F0: begin
                    case (scan_code)
                        8'hF0: state_d = GOT_E0F0;
                        8'hE0: state_d = GOT_E0;
                        8'h12, 8'h59: state_d = IDLE;
                        default: begin
                            emit      = 1'b1;
                            emit_data = {2'b11, scan_code};
                            state_d   = IDLE;
                        end
                    endcase
                end

                PAUSE: begin
                    // Swallow the rest of the 8-byte Pause sequence; the last
                    // swallowed byte stands in for the whole key.
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        emit      = 1'b1;
                        emit_data = {2'b10, 8'hE1};
                        state_d   = IDLE;
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Modifiers follow every decoded event, whether or not the FIFO has room.
    // -------------------------------------------------------------------------
    always_comb begin
        lshift_d = lshift_q;
        rshift_d = rshift_q;
        lctrl_d  = lctrl_q;
        rctrl_d  = rctrl_q;
        lalt_d   = lalt_q;
        ralt_d   = ralt_q;

        if (emit) begin
            case ({emit_data[9], emit_data[7:0]})
                9'h012:  lshift_d = ~emit_data[8];
                9'h059:  rshift_d = ~emit_data[8];
                9'h014:  lctrl_d  = ~emit_data[8];
                9'h114:  rctrl_d  = ~emit_data[8];
                9'h011:  lalt_d   = ~emit_data[8];
                9'h111:  ralt_d   = ~emit_data[8];
                default: ;
            endcase
        end

        shift_d = lshift_d | rshift_d;
        ctrl_d  = lctrl_d | rctrl_d;
        alt_d   = lalt_d | ralt_d;
    end

    // -------------------------------------------------------------------------
    // FIFO control. A pop frees the slot a same-edge push needs, so a full
    // FIFO still accepts a new event when the head is leaving.
    // -------------------------------------------------------------------------
    always_comb begin
        full = (count_q == FULL_COUNT);
        pop  = (count_q != '0) && evt_ready;
        push = emit && (!full || pop);
        drop = emit && full && !pop;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        // A drop on the clearing edge must remain visible.
        overflow_d = (overflow_q && !clear_ovf) || drop;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            skip_q     <= '0;
            lshift_q   <= 1'b0;
            rshift_q   <= 1'b0;
            lctrl_q    <= 1'b0;
            rctrl_q    <= 1'b0;
            lalt_q     <= 1'b0;
            ralt_q     <= 1'b0;
            shift_q    <= 1'b0;
            ctrl_q     <= 1'b0;
            alt_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            lshift_q   <= lshift_d;
            rshift_q   <= rshift_d;
            lctrl_q    <= lctrl_d;
            rctrl_q    <= rctrl_d;
            lalt_q     <= lalt_d;
            ralt_q     <= ralt_d;
            shift_q    <= shift_d;
            ctrl_q     <= ctrl_d;
            alt_q      <= alt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; count_q decides what
    // is visible, so stale entries never reach evt_data.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= emit_data;
        end
    end

    assign evt_valid = (count_q != '0);
    assign evt_data  = evt_valid ? mem_q[rd_ptr_q] : '0;
    assign shift     = shift_q;
    assign ctrl      = ctrl_q;
    assign alt       = alt_q;
    assign overflow  = overflow_q;

endmodule
